// File: rtl/alu_unit.sv
// Single-stage integer ALU for the out-of-order core: computes RV32I arithmetic,
// jump and branch results and registers them onto the ALU CDB slot one cycle after issue.
`ifndef DATA_WIDTH
`define DATA_WIDTH 31:0
`endif
`ifndef ROB_WIDTH
`define ROB_WIDTH 4:0
`endif
`ifndef ZERO_ROB
`define ZERO_ROB 0
`endif
`ifndef OPERATION_BUS
`define OPERATION_BUS 5:0
`endif

module alu_unit (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena,
  input  logic                  in_rollback,
  input  logic [`OPERATION_BUS] in_op,
  input  logic [`DATA_WIDTH]    in_Vj,
  input  logic [`DATA_WIDTH]    in_Vk,
  input  logic [`DATA_WIDTH]    in_imm,
  input  logic [`DATA_WIDTH]    in_pc,
  input  logic [`ROB_WIDTH]     in_rob_tag,
  output logic [`ROB_WIDTH]     out_cdb_rob_tag,
  output logic [`DATA_WIDTH]    out_cdb_data,
  output logic                  out_branch_valid,
  output logic                  out_branch_taken,
  output logic [`DATA_WIDTH]    out_branch_target
);

  localparam logic [`ROB_WIDTH] NO_TAG = `ZERO_ROB;

  localparam logic [5:0] OP_NOP   = 6'd0;
  localparam logic [5:0] OP_ADD   = 6'd1;
  localparam logic [5:0] OP_SUB   = 6'd2;
  localparam logic [5:0] OP_SLL   = 6'd3;
  localparam logic [5:0] OP_SLT   = 6'd4;
  localparam logic [5:0] OP_SLTU  = 6'd5;
  localparam logic [5:0] OP_XOR   = 6'd6;
  localparam logic [5:0] OP_SRL   = 6'd7;
  localparam logic [5:0] OP_SRA   = 6'd8;
  localparam logic [5:0] OP_OR    = 6'd9;
  localparam logic [5:0] OP_AND   = 6'd10;
  localparam logic [5:0] OP_ADDI  = 6'd11;
  localparam logic [5:0] OP_SLTI  = 6'd12;
  localparam logic [5:0] OP_SLTIU = 6'd13;
  localparam logic [5:0] OP_XORI  = 6'd14;
  localparam logic [5:0] OP_ORI   = 6'd15;
  localparam logic [5:0] OP_ANDI  = 6'd16;
  localparam logic [5:0] OP_SLLI  = 6'd17;
  localparam logic [5:0] OP_SRLI  = 6'd18;
  localparam logic [5:0] OP_SRAI  = 6'd19;
  localparam logic [5:0] OP_LUI   = 6'd20;
  localparam logic [5:0] OP_AUIPC = 6'd21;
  localparam logic [5:0] OP_JAL   = 6'd22;
  localparam logic [5:0] OP_JALR  = 6'd23;
  localparam logic [5:0] OP_BEQ   = 6'd24;
  localparam logic [5:0] OP_BNE   = 6'd25;
  localparam logic [5:0] OP_BLT   = 6'd26;
  localparam logic [5:0] OP_BGE   = 6'd27;
  localparam logic [5:0] OP_BLTU  = 6'd28;
  localparam logic [5:0] OP_BGEU  = 6'd29;

  logic [`ROB_WIDTH]  tag_d, tag_q;
  logic [`DATA_WIDTH] data_d, data_q;
  logic               bv_d, bv_q;
  logic               bt_d, bt_q;
  logic [`DATA_WIDTH] tgt_d, tgt_q;

  logic [`DATA_WIDTH] pc_plus4, pc_plus_imm, jalr_sum;
  logic [4:0]         sh_r, sh_i;

  assign pc_plus4    = in_pc + 32'd4;
  assign pc_plus_imm = in_pc + in_imm;
  assign jalr_sum    = in_Vj + in_imm;
  assign sh_r        = in_Vk[4:0];
  assign sh_i        = in_imm[4:0];

  always_comb begin
    tag_d  = in_rob_tag;
    data_d = '0;
    bv_d   = 1'b0;
    bt_d   = 1'b0;
    tgt_d  = '0;
    case (in_op)
      OP_ADD:   data_d = in_Vj + in_Vk;
      OP_SUB:   data_d = in_Vj - in_Vk;
      OP_SLL:   data_d = in_Vj << sh_r;
      OP_SLT:   data_d = {31'd0, $signed(in_Vj) < $signed(in_Vk)};
      OP_SLTU:  data_d = {31'd0, in_Vj < in_Vk};
      OP_XOR:   data_d = in_Vj ^ in_Vk;
      OP_SRL:   data_d = in_Vj >> sh_r;
      OP_SRA:   data_d = $unsigned($signed(in_Vj) >>> sh_r);
      OP_OR:    data_d = in_Vj | in_Vk;
      OP_AND:   data_d = in_Vj & in_Vk;
      OP_ADDI:  data_d = in_Vj + in_imm;
      OP_SLTI:  data_d = {31'd0, $signed(in_Vj) < $signed(in_imm)};
      OP_SLTIU: data_d = {31'd0, in_Vj < in_imm};
      OP_XORI:  data_d = in_Vj ^ in_imm;
      OP_ORI:   data_d = in_Vj | in_imm;
      OP_ANDI:  data_d = in_Vj & in_imm;
      OP_SLLI:  data_d = in_Vj << sh_i;
      OP_SRLI:  data_d = in_Vj >> sh_i;
      OP_SRAI:  data_d = $unsigned($signed(in_Vj) >>> sh_i);
      OP_LUI:   data_d = in_imm;
      OP_AUIPC: data_d = pc_plus_imm;
      OP_JAL: begin
        data_d = pc_plus4;
        bv_d   = 1'b1;
        bt_d   = 1'b1;
        tgt_d  = pc_plus_imm;
      end
      OP_JALR: begin
        data_d = pc_plus4;
        bv_d   = 1'b1;
        bt_d   = 1'b1;
        tgt_d  = {jalr_sum[31:1], 1'b0};
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        bv_d = 1'b1;
        case (in_op)
          OP_BEQ:  bt_d = (in_Vj == in_Vk);
          OP_BNE:  bt_d = (in_Vj != in_Vk);
          OP_BLT:  bt_d = ($signed(in_Vj) < $signed(in_Vk));
          OP_BGE:  bt_d = ($signed(in_Vj) >= $signed(in_Vk));
          OP_BLTU: bt_d = (in_Vj < in_Vk);
          default: bt_d = (in_Vj >= in_Vk);
        endcase
        tgt_d = bt_d ? pc_plus_imm : pc_plus4;
      end
      default:  tag_d = NO_TAG;
    endcase
    // A flush turns whatever was issued into a bubble.
    if (in_rollback || (in_op == OP_NOP)) begin
      tag_d  = NO_TAG;
      data_d = '0;
      bv_d   = 1'b0;
      bt_d   = 1'b0;
      tgt_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag_q  <= NO_TAG;
      data_q <= '0;
      bv_q   <= 1'b0;
      bt_q   <= 1'b0;
      tgt_q  <= '0;
    end else if (ena) begin
      tag_q  <= tag_d;
      data_q <= data_d;
      bv_q   <= bv_d;
      bt_q   <= bt_d;
      tgt_q  <= tgt_d;
    end
  end

  assign out_cdb_rob_tag   = tag_q;
  assign out_cdb_data      = data_q;
  assign out_branch_valid  = bv_q;
  assign out_branch_taken  = bt_q;
  assign out_branch_target = tgt_q;

endmodule
